// File: rtl/imem_loader.sv
// imem_loader: takes 32-bit instruction words over a valid/ready stream and
// writes them into a byte-wide, big-endian instruction memory, one byte per
// cycle, MSB first. It tracks the write pointer, bounds-checks each word
// against the memory size, and reports completion or error status.

module imem_loader #(
    parameter int MEM_SIZE = 4095,
    parameter int ADDR_W   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_word,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_overflow,
    output logic              err_align,
    output logic [ADDR_W-1:0] bytes_written
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_WORD = 3'd1,
        WRITE     = 3'd2,
        DONE      = 3'd3,
        ERROR     = 3'd4
    } state_t;

    // Highest pointer at which a whole 4-byte word still fits in memory.
    localparam logic [ADDR_W-1:0] LAST_OK = ADDR_W'(MEM_SIZE - 4);
    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] pointer;
    logic [31:0]       word_q;
    logic              last_q;
    logic [1:0]        idx;

    logic [ADDR_W-1:0] ptr_inc;
    logic [1:0]        idx_inc;

    assign ptr_inc = pointer + ONE;
    assign idx_inc = idx + 2'd1;

    // Big-endian byte select: index 0 is bits 31:24, index 3 is bits 7:0.
    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
        logic [7:0] b;
        case (i)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    // Session FSM. All outputs are registered and loaded together with the
    // next state, so each output always reflects the state it is paired with.
    // In particular in_ready is a pure state decode and never looks at
    // in_valid combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            pointer       <= '0;
            word_q        <= '0;
            last_q        <= 1'b0;
            idx           <= 2'd0;
            bytes_written <= '0;
            err_overflow  <= 1'b0;
            err_align     <= 1'b0;
            in_ready      <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        err_overflow  <= 1'b0;
                        bytes_written <= '0;
                        busy          <= 1'b1;
                        if (base_addr[1:0] != 2'b00) begin
                            err_align <= 1'b1;
                            state     <= ERROR;
                        end else begin
                            err_align <= 1'b0;
                            pointer   <= base_addr;
                            in_ready  <= 1'b1;
                            state     <= WAIT_WORD;
                        end
                    end
                end

                WAIT_WORD: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (pointer > LAST_OK) begin
                            // Word does not fit: drop it rather than write a
                            // partial word past the end of memory.
                            err_overflow <= 1'b1;
                            state        <= ERROR;
                        end else begin
                            word_q    <= in_word;
                            last_q    <= in_last;
                            idx       <= 2'd0;
                            mem_we    <= 1'b1;
                            mem_addr  <= pointer;
                            mem_wdata <= in_word[31:24];
                            state     <= WRITE;
                        end
                    end
                end

                WRITE: begin
                    // The byte for the current idx is on the bus this cycle;
                    // advance the counters and stage the next byte.
                    pointer       <= ptr_inc;
                    bytes_written <= bytes_written + ONE;
                    idx           <= idx_inc;
                    if (idx != 2'd3) begin
                        mem_addr  <= ptr_inc;
                        mem_wdata <= byte_sel(word_q, idx_inc);
                    end else begin
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        if (last_q) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= WAIT_WORD;
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                ERROR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    in_ready <= 1'b0;
                    mem_we   <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected byte writes are queued when a
// word is handed over and popped by a monitor as mem_we strobes appear.

module tb_imem_loader;

    localparam int MEM_SIZE = 4095;
    localparam int ADDR_W   = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_word;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              busy;
    logic              done;
    logic              err_overflow;
    logic              err_align;
    logic [ADDR_W-1:0] bytes_written;

    imem_loader #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_word      (in_word),
        .in_last      (in_last),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done),
        .err_overflow (err_overflow),
        .err_align    (err_align),
        .bytes_written(bytes_written)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    int  last_we_cyc = 0;
    int  done_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: compare every byte write against the scoreboard, check bus
    // quiescence between writes and the done pulse timing.
    always @(negedge clk) begin
        cyc++;
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_we", {56'b0, mem_wdata}, 64'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", mem_addr, e.addr);
                chk("wr_data", {56'b0, mem_wdata}, {56'b0, e.data});
            end
            chk("ready_in_write", {63'b0, in_ready}, 64'd0);
            last_we_cyc = cyc;
        end else if (reset === 1'b0 && cyc > 1) begin
            chk("idle_bus", mem_addr | {56'b0, mem_wdata}, 64'd0);
        end
        if (done === 1'b1) begin
            done_cnt++;
            chk("done_latency", 64'(cyc - last_we_cyc), 64'd1);
        end
    end

    task automatic push_word(input logic [ADDR_W-1:0] addr, input logic [31:0] w, input int nbytes);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < nbytes; i++) begin
            wr_t e;
            e.addr = addr + ADDR_W'(i);
            e.data = t[31:24];
            t = t << 8;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] a);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = a;
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = '0;
    endtask

    // Present a word after 'gap' idle cycles and return #1 after the edge
    // on which the handshake completed.
    task automatic send_word(input logic [31:0] w, input logic last, input int gap);
        bit ok;
        repeat (gap) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_word  = w;
        in_last  = last;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
            end
        end
        if (!ok) chk("handshake_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        in_word  = '0;
        in_last  = 1'b0;
    endtask

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        if (!ok) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int d0;
        reset = 1'b1; start = 1'b0; base_addr = '0;
        in_valid = 1'b0; in_word = '0; in_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
        chk("rst_mem_we", {63'b0, mem_we}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_errs", {62'b0, err_overflow, err_align}, 64'd0);
        chk("rst_bytes", bytes_written, 64'd0);
        reset = 1'b0;

        // Single word session at address 0.
        d0 = done_cnt;
        do_start(64'h0);
        push_word(64'h0, 32'h0050_0093, 4);
        send_word(32'h0050_0093, 1'b1, 0);
        wait_idle();
        chk("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t1_bytes", bytes_written, 64'd4);
        chk("t1_q_empty", 64'(exp_q.size()), 64'd0);
        chk("t1_busy", {63'b0, busy}, 64'd0);

        // Three words with gapped valid.
        d0 = done_cnt;
        do_start(64'h10);
        push_word(64'h10, 32'h0000_0013, 4);
        send_word(32'h0000_0013, 1'b0, 2);
        push_word(64'h14, 32'h0010_0093, 4);
        send_word(32'h0010_0093, 1'b0, 0);
        push_word(64'h18, 32'h0020_81B3, 4);
        send_word(32'h0020_81B3, 1'b1, 3);
        wait_idle();
        chk("t2_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t2_bytes", bytes_written, 64'd12);
        chk("t2_q_empty", 64'(exp_q.size()), 64'd0);

        // Overflow: second word at 4092 no longer fits.
        d0 = done_cnt;
        do_start(64'd4088);
        push_word(64'd4088, 32'hDEAD_BEEF, 4);
        send_word(32'hDEAD_BEEF, 1'b0, 0);
        send_word(32'hCAFE_F00D, 1'b1, 1);
        wait_idle();
        chk("t3_err_ovf", {63'b0, err_overflow}, 64'd1);
        chk("t3_err_align", {63'b0, err_align}, 64'd0);
        chk("t3_done_cnt", 64'(done_cnt - d0), 64'd0);
        chk("t3_bytes", bytes_written, 64'd4);
        chk("t3_q_empty", 64'(exp_q.size()), 64'd0);

        // Misaligned base, then a clean start clears the flag.
        do_start(64'h6);
        chk("t4_err_align", {63'b0, err_align}, 64'd1);
        chk("t4_ovf_cleared", {63'b0, err_overflow}, 64'd0);
        chk("t4_in_ready", {63'b0, in_ready}, 64'd0);
        wait_idle();
        chk("t4_align_sticky", {63'b0, err_align}, 64'd1);
        do_start(64'h0);
        chk("t4_align_clr", {63'b0, err_align}, 64'd0);
        push_word(64'h0, 32'h1122_3344, 4);
        send_word(32'h1122_3344, 1'b1, 0);
        wait_idle();
        chk("t4_bytes", bytes_written, 64'd4);

        // Reset during the index-2 byte write.
        do_start(64'h20);
        push_word(64'h20, 32'hA1B2_C3D4, 3);
        send_word(32'hA1B2_C3D4, 1'b1, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t5_mem_we", {63'b0, mem_we}, 64'd0);
        chk("t5_busy", {63'b0, busy}, 64'd0);
        chk("t5_outs", {61'b0, in_ready, done, err_overflow} | mem_addr | {56'b0, mem_wdata}, 64'd0);
        chk("t5_bytes", bytes_written, 64'd0);
        chk("t5_q_empty", 64'(exp_q.size()), 64'd0);
        reset = 1'b0;
        d0 = done_cnt;
        do_start(64'h20);
        push_word(64'h20, 32'h5566_7788, 4);
        send_word(32'h5566_7788, 1'b1, 1);
        wait_idle();
        chk("t5_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t5_bytes_after", bytes_written, 64'd4);

        // start while busy in WAIT_WORD is ignored.
        d0 = done_cnt;
        do_start(64'h40);
        push_word(64'h40, 32'h0BAD_F00D, 4);
        send_word(32'h0BAD_F00D, 1'b0, 0);
        wait_ready();
        do_start(64'h80);
        chk("t6_busy", {63'b0, busy}, 64'd1);
        push_word(64'h44, 32'h1357_9BDF, 4);
        send_word(32'h1357_9BDF, 1'b1, 0);
        wait_idle();
        chk("t6_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t6_bytes", bytes_written, 64'd8);
        chk("t6_q_empty", 64'(exp_q.size()), 64'd0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
